// File: rtl/branch_predictor_if.sv
// Fetch/decode signal bundle for the dynamic branch predictor.
// The predictor itself uses the slave side; the pipeline uses the master side.
interface branch_predictor_if;
  logic [31:0] pcF;
  logic        pred_takenF;
  logic        stallD;
  logic        flushD;
  logic        branchD;
  logic        actual_takenD;
  logic        mispredictD;
  logic        pred_takenD;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  modport master (
    output pcF, stallD, flushD, branchD, actual_takenD,
    input  pred_takenF, mispredictD, pred_takenD, hit_cnt, miss_cnt
  );

  modport slave (
    input  pcF, stallD, flushD, branchD, actual_takenD,
    output pred_takenF, mispredictD, pred_takenD, hit_cnt, miss_cnt
  );
endinterface

// File: rtl/branch_predictor.sv
// Two-bit saturating-counter branch predictor: predicts in fetch, trains in decode
// from the resolved comparator outcome, and keeps hit/miss statistics.
module branch_predictor #(
  parameter int         INDEX_W  = 6,
  parameter logic [1:0] CNT_INIT = 2'b01
) (
  input logic           clk,
  input logic           resetn,
  branch_predictor_if.slave bp
);
  localparam int ENTRIES = 1 << INDEX_W;

  logic [1:0]         counters [ENTRIES];
  logic [INDEX_W-1:0] idx_f;
  logic [INDEX_W-1:0] idx_d;
  logic               pred_d;
  logic               valid_d;
  logic               train;
  logic [1:0]         cnt_cur;
  logic [1:0]         cnt_next;
  logic [31:0]        hit_q;
  logic [31:0]        miss_q;
  logic               unused_pc;

  // Word-aligned PCs: the byte offset and upper bits never select an entry.
  assign idx_f     = bp.pcF[INDEX_W+1:2];
  assign unused_pc = ^{bp.pcF[31:INDEX_W+2], bp.pcF[1:0]};

  assign bp.pred_takenF = counters[idx_f][1];
  assign train          = valid_d & bp.branchD & ~bp.stallD;
  assign bp.mispredictD = valid_d & bp.branchD & (pred_d != bp.actual_takenD);
  assign bp.pred_takenD = pred_d;
  assign bp.hit_cnt     = hit_q;
  assign bp.miss_cnt    = miss_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pred_d  <= 1'b0;
      idx_d   <= '0;
      valid_d <= 1'b0;
    end else if (!bp.stallD) begin
      if (bp.flushD) begin
        valid_d <= 1'b0;
        pred_d  <= 1'b0;
      end else begin
        valid_d <= 1'b1;
        pred_d  <= bp.pred_takenF;
        idx_d   <= idx_f;
      end
    end
  end

  always_comb begin
    cnt_cur  = counters[idx_d];
    cnt_next = cnt_cur;
    if (bp.actual_takenD) begin
      if (cnt_cur != 2'b11) cnt_next = cnt_cur + 2'd1;
    end else begin
      if (cnt_cur != 2'b00) cnt_next = cnt_cur - 2'd1;
    end
  end

  // No read bypass: a fetch of the entry being trained sees the old value.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < ENTRIES; i++) counters[i] <= CNT_INIT;
    end else if (train) begin
      counters[idx_d] <= cnt_next;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else if (train) begin
      if (pred_d == bp.actual_takenD) hit_q <= hit_q + 32'd1;
      else                            miss_q <= miss_q + 32'd1;
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed-vector bench for branch_predictor: the stimulus pushes hand-computed
// expectations into a queue that a negedge monitor pops and compares.
module tb_branch_predictor;
  typedef struct {
    int          id;
    logic        pred_f;
    logic        pred_d;
    logic        mis;
    logic [31:0] hit;
    logic [31:0] miss;
  } exp_t;

  logic clk;
  logic resetn;
  int   vectors;
  int   miscompares;
  exp_t expq[$];

  branch_predictor_if bp ();

  branch_predictor #(.INDEX_W(6), .CNT_INIT(2'b01)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bp     (bp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input int id, input logic [31:0] pc,
                               input logic stall, input logic flush,
                               input logic branch, input logic actual,
                               input logic e_pf, input logic e_pd, input logic e_mis,
                               input logic [31:0] e_hit, input logic [31:0] e_miss);
    exp_t e;
    @(posedge clk);
    #1;
    bp.pcF           = pc;
    bp.stallD        = stall;
    bp.flushD        = flush;
    bp.branchD       = branch;
    bp.actual_takenD = actual;
    e.id     = id;
    e.pred_f = e_pf;
    e.pred_d = e_pd;
    e.mis    = e_mis;
    e.hit    = e_hit;
    e.miss   = e_miss;
    expq.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    logic bad;
    bad = 1'b0;
    vectors++;
    if (bp.pred_takenF !== e.pred_f) begin
      $display("[TB] FAIL vec%0d pred_takenF got %0b want %0b", e.id, bp.pred_takenF, e.pred_f);
      bad = 1'b1;
    end
    if (bp.pred_takenD !== e.pred_d) begin
      $display("[TB] FAIL vec%0d pred_takenD got %0b want %0b", e.id, bp.pred_takenD, e.pred_d);
      bad = 1'b1;
    end
    if (bp.mispredictD !== e.mis) begin
      $display("[TB] FAIL vec%0d mispredictD got %0b want %0b", e.id, bp.mispredictD, e.mis);
      bad = 1'b1;
    end
    if (bp.hit_cnt !== e.hit) begin
      $display("[TB] FAIL vec%0d hit_cnt got %0h want %0h", e.id, bp.hit_cnt, e.hit);
      bad = 1'b1;
    end
    if (bp.miss_cnt !== e.miss) begin
      $display("[TB] FAIL vec%0d miss_cnt got %0h want %0h", e.id, bp.miss_cnt, e.miss);
      bad = 1'b1;
    end
    if (bad) miscompares++;
  endtask

  // Monitor: every cycle with a pending expectation is compared at the negedge.
  initial begin
    forever begin
      @(negedge clk);
      if (expq.size() > 0) checkOutput(expq.pop_front());
    end
  end

  localparam logic [31:0] PC_I8  = 32'h0040_0020;
  localparam logic [31:0] PC_I1  = 32'h0040_0004;
  localparam logic [31:0] PC_I2  = 32'h0040_0008;
  localparam logic [31:0] PC_I4  = 32'h0040_0010;
  localparam logic [31:0] PC_A8  = 32'h0040_0120;

  initial begin
    int  waits;
    logic tbl_bad;
    vectors     = 0;
    miscompares = 0;
    resetn           = 1'b0;
    bp.pcF           = PC_I4;
    bp.stallD        = 1'b0;
    bp.flushD        = 1'b0;
    bp.branchD       = 1'b0;
    bp.actual_takenD = 1'b0;

    // Reset state
    applyStimulus(0, PC_I4, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    @(negedge clk);
    #1 resetn = 1'b1;

    // Train idx 8 toward taken: predictions 0,1,1
    applyStimulus(1,  PC_I8, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    applyStimulus(2,  PC_I1, 0, 0, 1, 1,  0, 0, 1, 0, 0);
    applyStimulus(3,  PC_I8, 0, 0, 0, 0,  1, 0, 0, 0, 1);
    applyStimulus(4,  PC_I1, 0, 0, 1, 1,  0, 1, 0, 0, 1);
    applyStimulus(5,  PC_I8, 0, 0, 0, 0,  1, 0, 0, 1, 1);
    applyStimulus(6,  PC_I1, 0, 0, 1, 1,  0, 1, 0, 1, 1);

    // Saturate down: predictions 1,1,0,0
    applyStimulus(7,  PC_I8, 0, 0, 0, 0,  1, 0, 0, 2, 1);
    applyStimulus(8,  PC_I1, 0, 0, 1, 0,  0, 1, 1, 2, 1);
    applyStimulus(9,  PC_I8, 0, 0, 0, 0,  1, 0, 0, 2, 2);
    applyStimulus(10, PC_I1, 0, 0, 1, 0,  0, 1, 1, 2, 2);
    applyStimulus(11, PC_I8, 0, 0, 0, 0,  0, 0, 0, 2, 3);
    applyStimulus(12, PC_I1, 0, 0, 1, 0,  0, 0, 0, 2, 3);
    applyStimulus(13, PC_I8, 0, 0, 0, 0,  0, 0, 0, 3, 3);
    applyStimulus(14, PC_I1, 0, 0, 1, 0,  0, 0, 0, 3, 3);

    // Stall: idx 2 primed to weak-T, then a not-taken branch held 3 cycles
    applyStimulus(15, PC_I2, 0, 0, 0, 0,  0, 0, 0, 4, 3);
    applyStimulus(16, PC_I1, 0, 0, 1, 1,  0, 0, 1, 4, 3);
    applyStimulus(17, PC_I2, 0, 0, 0, 0,  1, 0, 0, 4, 4);
    applyStimulus(18, PC_I1, 1, 0, 1, 0,  0, 1, 1, 4, 4);
    applyStimulus(19, PC_I2, 1, 0, 1, 0,  1, 1, 1, 4, 4);
    applyStimulus(20, PC_I1, 1, 0, 1, 0,  0, 1, 1, 4, 4);
    applyStimulus(21, PC_I1, 0, 0, 1, 0,  0, 1, 1, 4, 4);
    applyStimulus(22, PC_I2, 0, 0, 0, 0,  0, 0, 0, 4, 5);

    // Flush: bubble in D must not train or flag a mispredict
    applyStimulus(23, PC_I2, 0, 1, 0, 0,  0, 0, 0, 4, 5);
    applyStimulus(24, PC_I1, 0, 0, 1, 1,  0, 0, 0, 4, 5);
    applyStimulus(25, PC_I2, 0, 0, 0, 0,  0, 0, 0, 4, 5);

    // Alias + same-cycle read of the entry being trained
    applyStimulus(26, PC_I8, 0, 0, 0, 0,  0, 0, 0, 4, 5);
    applyStimulus(27, PC_I1, 0, 0, 1, 1,  0, 0, 1, 4, 5);
    applyStimulus(28, PC_I8, 0, 0, 0, 0,  0, 0, 0, 4, 6);
    applyStimulus(29, PC_A8, 0, 0, 1, 1,  0, 0, 1, 4, 6);
    applyStimulus(30, PC_A8, 0, 0, 0, 0,  1, 0, 0, 4, 7);

    // Miss counter wrap
    applyStimulus(31, PC_I1, 0, 0, 1, 0,  0, 1, 1, 4, 32'hFFFF_FFFF);
    force dut.miss_q = 32'hFFFF_FFFF;
    #1 release dut.miss_q;
    applyStimulus(32, PC_I1, 0, 0, 0, 0,  0, 0, 0, 4, 0);

    // Asynchronous reset in the middle of a stall
    applyStimulus(33, PC_I4, 1, 0, 1, 1,  0, 0, 0, 0, 0);
    #1 resetn = 1'b0;
    @(negedge clk);
    #1 resetn = 1'b1;

    vectors++;
    tbl_bad = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (dut.counters[i] !== 2'b01) begin
        $display("[TB] FAIL table_reset entry %0d got %0b want 01", i, dut.counters[i]);
        tbl_bad = 1'b1;
      end
    end
    if (tbl_bad) miscompares++;

    applyStimulus(34, PC_I4, 0, 0, 1, 1,  0, 0, 0, 0, 0);
    applyStimulus(35, PC_I4, 0, 0, 1, 1,  0, 0, 1, 0, 0);

    waits = 0;
    while (expq.size() > 0 && waits < 10) begin
      @(negedge clk);
      waits++;
    end
    #1;
    if (expq.size() > 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL drain %0d expectations left unchecked, want 0", expq.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Dynamic branch direction predictor for the 5-stage MIPS pipeline. It forms the other half of the decode-stage branch comparator.
- Fetch stage: predicts taken/not-taken for the current PC from a table of 2-bit saturating counters.
- Decode stage: receives the resolved branch outcome and trains the table. It also flags a misprediction so hazard/PC logic can redirect fetch.
- Keeps hit/miss statistics for performance counters.

Parameters:
- INDEX_W, 6, log2 of table entries; index = pc[INDEX_W+1:2].
- CNT_INIT, 2'b01, counter value after reset (weakly not-taken).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- resetn  input  1  asynchronous, active-low reset.
- pcF  input  32  fetch-stage PC.
- pred_takenF  output  1  prediction for pcF; combinational, counter MSB.
- stallD  input  1  hold the F->D prediction register and suppress training.
- flushD  input  1  invalidate the entry entering D (bubble).
- branchD  input  1  instruction in D is a conditional branch (BEQ/BNE/BGTZ/BLEZ/BGEZ/BLTZ/BGEZAL/BLTZAL).
- actual_takenD  input  1  resolved condition from the decode comparator.
- mispredictD  output  1  combinational: validD & branchD & (predD != actual_takenD).
- pred_takenD  output  1  registered prediction for the instruction in D.
- hit_cnt  output  32  count of correctly predicted branches.
- miss_cnt  output  32  count of mispredicted branches.

Behaviour:
- Table: 2^INDEX_W entries of 2-bit counters.
  - Encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Prediction = counter[1].
  - Lookup uses idxF = pcF[INDEX_W+1:2]. Zero-latency combinational read.
- F->D register: holds predD, idxD and validD.
  - resetn=0 (async): predD=0, idxD=0, validD=0.
  - stallD=1: hold all three.
  - else if flushD=1: validD<=0, predD<=0.
  - else: validD<=1, predD<=pred_takenF, idxD<=idxF.
  - stallD has priority over flushD.
- Training: train = validD & branchD & ~stallD. A stalled branch trains exactly once, on the cycle it leaves D.
  - actual_takenD=1: counter[idxD] <= sat_inc (11 stays 11).
  - actual_takenD=0: counter[idxD] <= sat_dec (00 stays 00).
- Same-cycle read/write of the same index: pred_takenF returns the pre-update value (no bypass). The new value is visible the next cycle.
- mispredictD is not gated by stallD. The consumer qualifies it.
- Statistics: on train, hit_cnt+1 if predD==actual_takenD, else miss_cnt+1.
  - Both counters are 32-bit and wrap 0xFFFFFFFF -> 0 silently.
- Reset (async, any time including mid-stall): every table entry = CNT_INIT; hit_cnt=0, miss_cnt=0; pred_takenD=0, mispredictD=0. Outputs settle without a clock edge.
- Aliasing: PCs sharing index bits share a counter. There are no tags.
- pcF[1:0] is ignored.

Test Plan:
- Reset state: assert resetn=0 mid-run, pcF=0x00400010 -> pred_takenF=0; hit_cnt=miss_cnt=0; all 64 entries read 01 after release.
- Training to taken: same branch at pcF=0x00400020 (idx 8), actual_takenD=1 three times -> predictions 0,1,1; counter 01->10->11->11; miss_cnt=1, hit_cnt=2; mispredictD=1 only on the first.
- Saturation down: from 11, four not-taken resolutions -> counter 10,01,00,00; predictions 1,1,0,0.
- Stall: branchD=1 held with stallD=1 for 3 cycles, then released -> exactly one counter update and one statistics increment; predD unchanged during the stall.
- Flush: flushD=1 while a branch is fetched -> next cycle validD=0; branchD=1 causes no update and mispredictD=0.
- Alias and same-cycle update: pcF=0x00400120 (idx 8) fetched in the same cycle idx 8 is trained 01->10 -> pred_takenF=0 that cycle, 1 the next.
- Counter wrap: preload miss_cnt=0xFFFFFFFF (force), one miss -> miss_cnt=0.
